cast5_arbiter: RTL and testbench

CAST5_ARBITER -- requirements
Module: cast5_arbiter

---
 rtl/cast5_pkg.sv | 16 +
 rtl/cast5_arbiter_if.sv | 37 +++
 rtl/cast5_rr_arb2.sv | 26 ++
 rtl/cast5_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_cast5_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cast5_pkg.sv
// Shared constants and FSM encoding for the CAST5 request arbiter.
package cast5_pkg;

    localparam int CAST5_KEY_W   = 128;
    localparam int CAST5_BLK_W   = 64;
    localparam int CAST5_TMO_DEF = 1023;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_GRANT     = 3'd1;
    localparam logic [2:0] S_KEY_LOAD  = 3'd2;
    localparam logic [2:0] S_KEY_WAIT  = 3'd3;
    localparam logic [2:0] S_DATA      = 3'd4;
    localparam logic [2:0] S_DATA_WAIT = 3'd5;
    localparam logic [2:0] S_RESP      = 3'd6;

endpackage

// File: rtl/cast5_arbiter_if.sv
// Requester-side request/response bundle for the two CAST5 clients.
interface cast5_arbiter_if;
    import cast5_pkg::*;

    logic                   i_req0_vld;
    logic                   o_req0_rdy;
    logic                   i_req0_flag;
    logic [CAST5_KEY_W-1:0] i_req0_key;
    logic [CAST5_BLK_W-1:0] i_req0_din;
    logic                   o_resp0_vld;
    logic [CAST5_BLK_W-1:0] o_resp0_dout;
    logic                   o_resp0_err;

    logic                   i_req1_vld;
    logic                   o_req1_rdy;
    logic                   i_req1_flag;
    logic [CAST5_KEY_W-1:0] i_req1_key;
    logic [CAST5_BLK_W-1:0] i_req1_din;
    logic                   o_resp1_vld;
    logic [CAST5_BLK_W-1:0] o_resp1_dout;
    logic                   o_resp1_err;

    modport master (
        output i_req0_vld, i_req0_flag, i_req0_key, i_req0_din,
        output i_req1_vld, i_req1_flag, i_req1_key, i_req1_din,
        input  o_req0_rdy, o_resp0_vld, o_resp0_dout, o_resp0_err,
        input  o_req1_rdy, o_resp1_vld, o_resp1_dout, o_resp1_err
    );

    modport slave (
        input  i_req0_vld, i_req0_flag, i_req0_key, i_req0_din,
        input  i_req1_vld, i_req1_flag, i_req1_key, i_req1_din,
        output o_req0_rdy, o_resp0_vld, o_resp0_dout, o_resp0_err,
        output o_req1_rdy, o_resp1_vld, o_resp1_dout, o_resp1_err
    );

endinterface

// File: rtl/cast5_rr_arb2.sv
// Two-input round-robin arbiter; favours the input not served last.
module cast5_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    // last_q = 1 makes requester 0 the first winner after reset
    logic last_q;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11)
            gnt_o = last_q ? 2'b01 : 2'b10;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            last_q <= 1'b1;
        else if (adv_i && |req_i)
            last_q <= gnt_o[1];
    end

endmodule

// File: rtl/cast5_arbiter.sv
// Two-requester front end for a shared CAST5 core.
// Optional key cache: define CAST5_ARB_KEY_CACHE_EN.
module cast5_arbiter
    import cast5_pkg::*;
#(
    parameter int TMO_CYCLES = CAST5_TMO_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    cast5_arbiter_if.slave         bus,
    output logic                   o_core_key_en,
    output logic [CAST5_KEY_W-1:0] o_core_key,
    output logic                   o_core_flag,
    output logic                   o_core_din_en,
    output logic [CAST5_BLK_W-1:0] o_core_din,
    input  logic                   i_core_key_ok,
    input  logic [CAST5_BLK_W-1:0] i_core_dout,
    input  logic                   i_core_dout_en,
    output logic                   o_busy
);

    localparam int CW = $clog2(TMO_CYCLES + 1);

    logic [2:0]             state_q, state_d;
    logic [1:0]             gnt_q;
    logic [1:0]             gnt;
    logic [1:0]             req;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   flag_q;
    logic [CAST5_BLK_W-1:0] din_q;
    logic [CAST5_KEY_W-1:0] ckey_q;
    logic [CAST5_BLK_W-1:0] cdin_q;
    logic                   cflag_q;
    logic [CAST5_BLK_W-1:0] resp_q;
    logic                   err_q;

    logic                   sel_flag;
    logic [CAST5_KEY_W-1:0] sel_key;
    logic [CAST5_BLK_W-1:0] sel_din;
    logic                   reload;
    logic                   tmo;
    logic                   key_go;
    logic                   good;
    logic                   abort;

    assign req = {bus.i_req1_vld, bus.i_req0_vld};

    cast5_rr_arb2 u_rr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .req_i   (req),
        .adv_i   (state_q == S_IDLE),
        .gnt_o   (gnt)
    );

    assign sel_flag = gnt_q[1] ? bus.i_req1_flag : bus.i_req0_flag;
    assign sel_key  = gnt_q[1] ? bus.i_req1_key  : bus.i_req0_key;
    assign sel_din  = gnt_q[1] ? bus.i_req1_din  : bus.i_req0_din;

    assign tmo    = (cnt_q == CW'(TMO_CYCLES));
    // key_ok is stale in the first KEY_WAIT cycle, which is cnt_q == 0
    assign key_go = i_core_key_ok && (cnt_q != '0);
    assign good   = (state_q == S_DATA_WAIT) && i_core_dout_en;
    assign abort  = (state_d == S_RESP) && !good;

`ifdef CAST5_ARB_KEY_CACHE_EN
    logic [CAST5_KEY_W-1:0] cache_q;
    logic                   tag_q;

    assign reload = !tag_q || (sel_key != cache_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cache_q <= '0;
            tag_q   <= 1'b0;
        end else if (state_q == S_KEY_WAIT && key_go) begin
            cache_q <= ckey_q;
            tag_q   <= 1'b1;
        end else if (abort) begin
            tag_q   <= 1'b0;
        end else if (state_q == S_GRANT && reload) begin
            tag_q   <= 1'b0;
        end
    end
`else
    assign reload = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req)
                    state_d = S_GRANT;
            end
            S_GRANT: begin
                state_d = reload ? S_KEY_LOAD : S_DATA;
            end
            S_KEY_LOAD: begin
                state_d = S_KEY_WAIT;
                cnt_d   = '0;
            end
            S_KEY_WAIT: begin
                if (key_go)
                    state_d = S_DATA;
                else if (tmo)
                    state_d = S_RESP;
                else
                    cnt_d = cnt_q + CW'(1);
            end
            S_DATA: begin
                state_d = S_DATA_WAIT;
                cnt_d   = '0;
            end
            S_DATA_WAIT: begin
                if (i_core_dout_en || tmo)
                    state_d = S_RESP;
                else
                    cnt_d = cnt_q + CW'(1);
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            din_q   <= '0;
            ckey_q  <= '0;
            cdin_q  <= '0;
            cflag_q <= 1'b0;
            resp_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && |req)
                gnt_q <= gnt;
            if (state_q == S_GRANT) begin
                flag_q <= sel_flag;
                din_q  <= sel_din;
                if (reload)
                    ckey_q <= sel_key;
            end
            // core-facing data only moves on entry to DATA
            if (state_q == S_GRANT && !reload) begin
                cdin_q  <= sel_din;
                cflag_q <= sel_flag;
            end else if (state_q == S_KEY_WAIT && key_go) begin
                cdin_q  <= din_q;
                cflag_q <= flag_q;
            end
            if (good) begin
                resp_q <= i_core_dout;
                err_q  <= 1'b0;
            end else if (abort) begin
                resp_q <= '0;
                err_q  <= 1'b1;
            end
        end
    end

    assign bus.o_req0_rdy   = (state_q == S_GRANT) && gnt_q[0];
    assign bus.o_req1_rdy   = (state_q == S_GRANT) && gnt_q[1];
    assign bus.o_resp0_vld  = (state_q == S_RESP) && gnt_q[0];
    assign bus.o_resp1_vld  = (state_q == S_RESP) && gnt_q[1];
    assign bus.o_resp0_dout = resp_q;
    assign bus.o_resp1_dout = resp_q;
    assign bus.o_resp0_err  = err_q;
    assign bus.o_resp1_err  = err_q;

    assign o_core_key_en = (state_q == S_KEY_LOAD);
    assign o_core_key    = ckey_q;
    assign o_core_din_en = (state_q == S_DATA);
    assign o_core_din    = cdin_q;
    assign o_core_flag   = cflag_q;
    assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_cast5_arbiter.sv
// Scoreboard bench for cast5_arbiter with a behavioural CAST5 core stand-in.
module tb_cast5_arbiter;
    import cast5_pkg::*;

    localparam int TMO = 15;
    localparam logic [127:0] K1 = 128'h0123456712345678234567893456789A;
    localparam logic [127:0] K2 = 128'hCAFEBABE_00112233_44556677_8899AABB;
    localparam logic [127:0] KA = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] KB = 128'h55555555_66666666_77777777_88888888;
    localparam logic [63:0]  P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0]  C1 = 64'h238B4FE5847E44B2;

`ifdef CAST5_ARB_KEY_CACHE_EN
    localparam int CACHE_KEYEN = 1;
`else
    localparam int CACHE_KEYEN = 2;
`endif

    typedef struct {
        logic [63:0] dout;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cast5_arbiter_if bus();

    logic          core_key_en, core_flag, core_din_en, busy;
    logic [127:0]  core_key;
    logic [63:0]   core_din;
    logic          m_key_ok, m_dout_en, stray;
    logic [63:0]   m_dout, m_res;
    logic [127:0]  m_key;
    int            m_kdly, m_ddly;
    int            core_lat = 3;
    bit            core_hang = 1'b0;

    cast5_arbiter #(.TMO_CYCLES(TMO)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .bus            (bus),
        .o_core_key_en  (core_key_en),
        .o_core_key     (core_key),
        .o_core_flag    (core_flag),
        .o_core_din_en  (core_din_en),
        .o_core_din     (core_din),
        .i_core_key_ok  (m_key_ok),
        .i_core_dout    (m_dout),
        .i_core_dout_en (m_dout_en | stray),
        .o_busy         (busy)
    );

    function automatic logic [63:0] core_fn(input logic [127:0] k,
                                            input logic f,
                                            input logic [63:0] d);
        if (k == K1 && f && d == P1) return C1;
        if (k == K1 && !f && d == C1) return P1;
        return f ? (d ^ k[63:0]) : (d ^ k[127:64]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_key_ok  <= 1'b0;
            m_kdly    <= 0;
            m_key     <= '0;
            m_dout_en <= 1'b0;
            m_dout    <= '0;
            m_res     <= '0;
            m_ddly    <= 0;
        end else begin
            if (core_key_en) begin
                m_key_ok <= 1'b0;
                m_kdly   <= 2;
                m_key    <= core_key;
            end else if (m_kdly != 0) begin
                m_kdly <= m_kdly - 1;
                if (m_kdly == 1) m_key_ok <= 1'b1;
            end
            m_dout_en <= 1'b0;
            if (core_din_en && !core_hang) begin
                m_ddly <= core_lat;
                m_res  <= core_fn(m_key, core_flag, core_din);
            end else if (m_ddly != 0) begin
                m_ddly <= m_ddly - 1;
                if (m_ddly == 1) begin
                    m_dout_en <= 1'b1;
                    m_dout    <= m_res;
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk = 0;
    int   n_pass = 0;
    int   n_keyen = 0;
    int   din_cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   gq[$];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic mon_resp(input int n, input logic vld,
                            input logic err, input logic [63:0] dout);
        exp_t e;
        if (!vld) return;
        if ((n == 0 ? q0.size() : q1.size()) == 0) begin
            chk($sformatf("resp%0d_unexpected", n), 1, 0);
            return;
        end
        e = (n == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("resp%0d_data", n), {err, dout}, {e.err, e.dout});
        if (e.lat != 0)
            chk($sformatf("resp%0d_lat", n), cyc - din_cyc, e.lat);
    endtask

    initial forever begin
        @(negedge clk);
        if (core_din_en) din_cyc = cyc;
        if (core_key_en) n_keyen++;
        if (bus.o_req0_rdy || bus.o_req1_rdy) begin
            chk("rdy_excl", bus.o_req0_rdy & bus.o_req1_rdy, 0);
            if (gq.size() == 0) chk("gnt_unexpected", 1, 0);
            else chk("gnt_order", bus.o_req1_rdy ? 1 : 0, gq.pop_front());
        end
        mon_resp(0, bus.o_resp0_vld, bus.o_resp0_err, bus.o_resp0_dout);
        mon_resp(1, bus.o_resp1_vld, bus.o_resp1_err, bus.o_resp1_dout);
    end

    task automatic drv(input int n, input logic [127:0] k, input logic f,
                       input logic [63:0] d, input bit push,
                       input logic [63:0] edout, input logic eerr,
                       input int lat);
        exp_t e;
        int   t;
        logic rdy;
        e.dout = edout;
        e.err  = eerr;
        e.lat  = lat;
        if (push) begin
            if (n == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        if (n == 0) begin
            bus.i_req0_key = k; bus.i_req0_flag = f;
            bus.i_req0_din = d; bus.i_req0_vld = 1'b1;
        end else begin
            bus.i_req1_key = k; bus.i_req1_flag = f;
            bus.i_req1_din = d; bus.i_req1_vld = 1'b1;
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
            rdy = (n == 0) ? bus.o_req0_rdy : bus.o_req1_rdy;
        end while (!rdy && t < 300);
        if (!rdy) chk($sformatf("req%0d_accept_timeout", n), 0, 1);
        @(posedge clk);
        #1;
        if (n == 0) bus.i_req0_vld = 1'b0;
        else bus.i_req1_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((q0.size() != 0 || q1.size() != 0 || busy) && t < 400);
        if (busy || q0.size() != 0 || q1.size() != 0)
            chk("idle_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, {busy, bus.o_req0_rdy, bus.o_req1_rdy,
            bus.o_resp0_vld, bus.o_resp1_vld, bus.o_resp0_err,
            bus.o_resp1_err, core_key_en, core_din_en, core_flag}, 0);
        chk({nm, "_key"}, core_key, 0);
        chk({nm, "_dat"}, {core_din, bus.o_resp0_dout | bus.o_resp1_dout}, 0);
    endtask

    int k0;
    int t;

    initial begin
        bus.i_req0_vld = 0; bus.i_req0_flag = 0;
        bus.i_req0_key = '0; bus.i_req0_din = '0;
        bus.i_req1_vld = 0; bus.i_req1_flag = 0;
        bus.i_req1_key = '0; bus.i_req1_din = '0;
        stray = 1'b0;

        repeat (3) @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single encrypt on requester 0, fresh after reset
        k0 = n_keyen;
        gq.push_back(0);
        drv(0, K1, 1'b1, P1, 1, C1, 1'b0, 5);
        wait_idle();
        chk("enc_keyen", n_keyen - k0, 1);

        // decrypt on requester 1
        gq.push_back(1);
        drv(1, K1, 1'b0, C1, 1, P1, 1'b0, 5);
        wait_idle();

        // both valid for four transactions
        gq.push_back(0); gq.push_back(1);
        gq.push_back(0); gq.push_back(1);
        fork
            begin
                drv(0, KA, 1'b1, 64'h1, 1, core_fn(KA, 1'b1, 64'h1), 1'b0, 5);
                drv(0, KA, 1'b0, 64'h2, 1, core_fn(KA, 1'b0, 64'h2), 1'b0, 5);
            end
            begin
                drv(1, KB, 1'b1, 64'h3, 1, core_fn(KB, 1'b1, 64'h3), 1'b0, 5);
                drv(1, KB, 1'b1, 64'h4, 1, core_fn(KB, 1'b1, 64'h4), 1'b0, 5);
            end
        join
        wait_idle();

        // back-to-back with the same key
        k0 = n_keyen;
        gq.push_back(0); gq.push_back(0);
        drv(0, K2, 1'b1, 64'hA0, 1, core_fn(K2, 1'b1, 64'hA0), 1'b0, 5);
        drv(0, K2, 1'b0, 64'hA1, 1, core_fn(K2, 1'b0, 64'hA1), 1'b0, 5);
        wait_idle();
        chk("cache_keyen", n_keyen - k0, CACHE_KEYEN);

        // stray dout_en while idle must be ignored
        @(posedge clk); #1 stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_idle", busy, 0);

        // dout_en lands on the timeout cycle: good response wins
        core_lat = 15;
        gq.push_back(1);
        drv(1, K2, 1'b1, 64'hB0, 1, core_fn(K2, 1'b1, 64'hB0), 1'b0, 17);
        wait_idle();
        core_lat = 3;

        // core never answers: error response, then key reload
        core_hang = 1'b1;
        gq.push_back(0);
        drv(0, K2, 1'b1, 64'hC0, 1, 64'h0, 1'b1, TMO + 2);
        wait_idle();
        core_hang = 1'b0;
        k0 = n_keyen;
        gq.push_back(1);
        drv(1, K2, 1'b1, 64'hC1, 1, core_fn(K2, 1'b1, 64'hC1), 1'b0, 5);
        wait_idle();
        chk("tmo_reload_keyen", n_keyen - k0, 1);

        // reset in DATA_WAIT: no response, outputs cleared
        gq.push_back(0);
        drv(0, K2, 1'b1, 64'hD0, 0, 64'h0, 1'b0, 0);
        t = 0;
        while (!core_din_en && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rst_reach_data", core_din_en, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        repeat (2) @(negedge clk);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        k0 = n_keyen;
        gq.push_back(0);
        drv(0, K2, 1'b1, 64'hD1, 1, core_fn(K2, 1'b1, 64'hD1), 1'b0, 5);
        wait_idle();
        chk("rst_reload_keyen", n_keyen - k0, 1);
        chk("gnt_queue_drained", gq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
